pong_score_keeper: RTL and testbench
====================================

Name: pong_score_keeper

Overview:
Match control and score stage for the pong game. It consumes the one-cycle slow tick produced by the clock divider stage (one pulse every 50,000,001 clocks) as its time base for serve delays and game-over blinking. It also counts points reported by the ball logic and declares a winner. Its outputs feed the score display and gate the ball/paddle logic through serve_en.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..9.
SERVE_TICKS, 3, tick pulses to wait before each serve; legal range 1..15.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
tick  input  1  one-cycle enable pulse from the divider; never a clock.
start  input  1  level or pulse, sampled every cycle; begins or restarts a match.
point_p1  input  1  one-cycle pulse: player 1 scored.
point_p2  input  1  one-cycle pulse: player 2 scored.
score_p1  output  4  player 1 score, binary 0..9.
score_p2  output  4  player 2 score, binary 0..9.
serve_en  output  1  high only in PLAY; ball logic runs only while high.
serve_side  output  1  0 = serve toward player 1, 1 = toward player 2.
game_over  output  1  high in GAME_OVER.
winner  output  2  00 none, 01 player 1, 10 player 2.
blink  output  1  toggles on each tick in GAME_OVER; 0 otherwise.

Behaviour:
- Reset, applied on a posedge with reset=1: state=IDLE, scores=0, cnt=0, serve_en=0, serve_side=0, game_over=0, winner=00, blink=0. Reset overrides every other input and acts the same mid-match.
- All outputs are registered. State and score changes appear one clock after the qualifying input edge.
- States are IDLE, SERVE_WAIT, PLAY and GAME_OVER.
- IDLE:
  - On start=1: clear scores, winner=00, load cnt=SERVE_TICKS, go to SERVE_WAIT.
  - A tick in the same cycle as start is not counted.
- SERVE_WAIT:
  - On each tick, cnt decrements.
  - On a tick with cnt==1: cnt=0 and go to PLAY.
  - Point pulses are ignored. start is ignored.
- PLAY:
  - serve_en=1.
  - point_p1 alone: score_p1+1 and serve_side=1 (the conceding player 2 receives the serve).
  - point_p2 alone: score_p2+1 and serve_side=0.
  - If the incremented score equals WIN_SCORE: go to GAME_OVER, winner=01 or 10, blink=0.
  - Otherwise: load cnt=SERVE_TICKS and go to SERVE_WAIT.
  - point_p1 and point_p2 in the same cycle: no score change, serve_side unchanged, cnt=SERVE_TICKS, go to SERVE_WAIT (re-serve).
  - tick has no effect in PLAY.
- GAME_OVER:
  - game_over=1. Scores and winner are held.
  - blink inverts on every tick.
  - On start=1: behaves as start in IDLE (scores cleared, winner=00, blink=0, cnt=SERVE_TICKS, SERVE_WAIT). serve_side is kept.
- Scores never exceed WIN_SCORE (≤9), so there is no wrap-around.
- cnt is 4 bits and never underflows.
- Only a tick pulse advances time. A continuous tick=1 advances one count per clock; the bench uses this for speed.

Test Plan:
- Reset then start=1 for 1 cycle with SERVE_TICKS=3 → SERVE_WAIT. serve_en stays 0 through 2 ticks and goes to 1 one clock after the 3rd tick.
- In PLAY, one point_p1 pulse → next clock score_p1=1, serve_side=1, serve_en=0. After 3 ticks serve_en=1 again.
- Drive 7 point_p2 rallies (WIN_SCORE=7) → score_p2=7, game_over=1, winner=10, serve_en=0. Further point pulses leave scores unchanged. 4 ticks give blink sequence 1,0,1,0.
- point_p1 and point_p2 asserted together in PLAY → scores unchanged, SERVE_WAIT entered, serve_side unchanged.
- Point pulses during SERVE_WAIT and IDLE → no score change. Start coincident with a tick in IDLE → full SERVE_TICKS ticks still required.
- reset=1 for one cycle mid-PLAY with score 3–2 → next clock all outputs at reset values, state IDLE. start during GAME_OVER → scores 0–0, winner=00, SERVE_WAIT.

Source files
------------

// File: rtl/pong_score_keeper.sv
// ---------------------------------------------------------------------------
// pong_score_keeper
//
// Match control and score stage for the pong game. It uses the one-cycle
// slow tick from the clock divider as its time base. The tick sets the serve
// delay and the game-over blink rate. The block counts points reported by the
// ball logic, declares a winner, and gates the ball/paddle logic via serve_en.
//
// Parameters
//   WIN_SCORE    points needed to win (1..9)
//   SERVE_TICKS  tick pulses to wait before each serve (1..15)
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   tick        in   one-cycle enable pulse from the divider (not a clock)
//   start       in   begins / restarts a match (level or pulse)
//   point_p1    in   one-cycle pulse: player 1 scored
//   point_p2    in   one-cycle pulse: player 2 scored
//   score_p1    out  player 1 score, binary 0..9
//   score_p2    out  player 2 score, binary 0..9
//   serve_en    out  high only while the ball is in play
//   serve_side  out  0 = serve toward player 1, 1 = toward player 2
//   game_over   out  high once a player has reached WIN_SCORE
//   winner      out  00 none, 01 player 1, 10 player 2
//   blink       out  toggles on each tick after the match ends, else 0
// ---------------------------------------------------------------------------
module pong_score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve_en,
  output logic       serve_side,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
  localparam logic [3:0] SERVE_L = 4'(SERVE_TICKS);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] score_p1_nx, score_p2_nx;
  logic       serve_side_nx;
  logic [1:0] winner_nx;
  logic       blink_nx;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would infer a latch.
    state_nx      = state;
    cnt_nx        = cnt;
    score_p1_nx   = score_p1;
    score_p2_nx   = score_p2;
    serve_side_nx = serve_side;
    winner_nx     = winner;
    blink_nx      = blink;

    case (state)
      IDLE: begin
        // A tick in the same cycle as start is deliberately not counted:
        // the full serve delay always follows a start.
        if (start) begin
          score_p1_nx = '0;
          score_p2_nx = '0;
          winner_nx   = 2'b00;
          blink_nx    = 1'b0;
          cnt_nx      = SERVE_L;
          state_nx    = SERVE_WAIT;
        end
      end

      SERVE_WAIT: begin
        // Points and start are ignored while waiting for the serve.
        if (tick && cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) state_nx = PLAY;
        end
      end

      PLAY: begin
        if (point_p1 && point_p2) begin
          // Simultaneous points: nobody scores, the rally is re-served.
          cnt_nx   = SERVE_L;
          state_nx = SERVE_WAIT;
        end else if (point_p1) begin
          score_p1_nx   = score_p1 + 4'd1;
          serve_side_nx = 1'b1;
          if (score_p1_nx == WIN_L) begin
            winner_nx = 2'b01;
            blink_nx  = 1'b0;
            state_nx  = GAME_OVER;
          end else begin
            cnt_nx   = SERVE_L;
            state_nx = SERVE_WAIT;
          end
        end else if (point_p2) begin
          score_p2_nx   = score_p2 + 4'd1;
          serve_side_nx = 1'b0;
          if (score_p2_nx == WIN_L) begin
            winner_nx = 2'b10;
            blink_nx  = 1'b0;
            state_nx  = GAME_OVER;
          end else begin
            cnt_nx   = SERVE_L;
            state_nx = SERVE_WAIT;
          end
        end
      end

      GAME_OVER: begin
        // A restart takes priority over a coincident blink tick; the
        // serve side of the last point is carried into the new match.
        if (start) begin
          score_p1_nx = '0;
          score_p2_nx = '0;
          winner_nx   = 2'b00;
          blink_nx    = 1'b0;
          cnt_nx      = SERVE_L;
          state_nx    = SERVE_WAIT;
        end else if (tick) begin
          blink_nx = ~blink;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before this edge.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      score_p1   <= '0;
      score_p2   <= '0;
      serve_en   <= 1'b0;
      serve_side <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      blink      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      score_p1   <= score_p1_nx;
      score_p2   <= score_p2_nx;
      serve_en   <= (state_nx == PLAY);
      serve_side <= serve_side_nx;
      game_over  <= (state_nx == GAME_OVER);
      winner     <= winner_nx;
      blink      <= blink_nx;
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_pong_score_keeper
//
// Self-checking bench for pong_score_keeper. A match-level model follows the
// game rules (phase, remaining serve ticks, scores, serve side, winner,
// blink). A negedge compare process checks every DUT output against it on
// every cycle after the first reset. Directed stimulus walks the match
// scenarios. Hand-computed literal checks at key points pin the model.
// ---------------------------------------------------------------------------
module tb_pong_score_keeper;

  localparam int WIN = 7;
  localparam int ST  = 3;

  // Model phases.
  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_PLAY = 2;
  localparam int PH_OVER = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, start = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve_en, serve_side, game_over, blink;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Match-level model.
  int m_phase = PH_IDLE;
  int m_left  = 0;
  int m_s1 = 0, m_s2 = 0, m_side = 0, m_win = 0, m_blink = 0;

  pong_score_keeper #(.WIN_SCORE(WIN), .SERVE_TICKS(ST)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .point_p1   (point_p1),
    .point_p2   (point_p2),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .serve_en   (serve_en),
    .serve_side (serve_side),
    .game_over  (game_over),
    .winner     (winner),
    .blink      (blink)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the game rules once per clock, from the inputs held across the edge.
  always @(posedge clock) begin
    if (reset) begin
      m_phase = PH_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0;
      m_side = 0; m_win = 0; m_blink = 0;
    end else if (m_phase == PH_IDLE || (m_phase == PH_OVER && start)) begin
      if (start) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_blink = 0;
        m_left = ST; m_phase = PH_WAIT;
      end
    end else if (m_phase == PH_OVER) begin
      if (tick) m_blink = 1 - m_blink;
    end else if (m_phase == PH_WAIT) begin
      if (tick) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = PH_PLAY;
      end
    end else if (point_p1 && point_p2) begin
      m_left = ST; m_phase = PH_WAIT;
    end else if (point_p1 || point_p2) begin
      if (point_p1) begin m_s1++; m_side = 1; end
      else          begin m_s2++; m_side = 0; end
      if (m_s1 == WIN || m_s2 == WIN) begin
        m_win = (m_s1 == WIN) ? 1 : 2;
        m_blink = 0; m_phase = PH_OVER;
      end else begin
        m_left = ST; m_phase = PH_WAIT;
      end
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clock) begin
    if (cmp_on) begin
      check("score_p1",   int'(score_p1),   m_s1);
      check("score_p2",   int'(score_p2),   m_s2);
      check("serve_en",   int'(serve_en),   int'(m_phase == PH_PLAY));
      check("serve_side", int'(serve_side), m_side);
      check("game_over",  int'(game_over),  int'(m_phase == PH_OVER));
      check("winner",     int'(winner),     m_win);
      check("blink",      int'(blink),      m_blink);
    end
  end

  // One clock with the given inputs; returns at the following negedge.
  task automatic cyc(input bit r, input bit s, input bit t, input bit a, input bit b);
    reset = r; start = s; tick = t; point_p1 = a; point_p2 = b;
    @(negedge clock);
    reset = 0; start = 0; tick = 0; point_p1 = 0; point_p2 = 0;
  endtask

  task automatic serve_delay();
    for (int i = 0; i < ST; i++) cyc(0, 0, 1, 0, 0);
  endtask

  initial begin
    @(negedge clock);
    cyc(1, 0, 0, 0, 0);
    cmp_on = 1'b1;

    // Reset state.
    check("rst_score_p1", int'(score_p1), 0);
    check("rst_serve_en", int'(serve_en), 0);
    check("rst_winner",   int'(winner),   0);

    // Points in IDLE do nothing.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    check("idle_pts_s1", int'(score_p1), 0);

    // Start coincident with a tick: full serve delay still required.
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 1);            // start and points ignored in SERVE_WAIT
    check("wait_pts_s1", int'(score_p1), 0);
    cyc(0, 0, 1, 0, 0);
    check("sw_2ticks_en", int'(serve_en), 0);
    cyc(0, 0, 1, 0, 0);
    check("sw_3ticks_en", int'(serve_en), 1);

    // tick has no effect in PLAY.
    cyc(0, 0, 1, 0, 0);
    check("play_tick_en", int'(serve_en), 1);

    // Single point to player 1.
    cyc(0, 0, 0, 1, 0);
    check("p1_point_s1",   int'(score_p1),   1);
    check("p1_point_side", int'(serve_side), 1);
    check("p1_point_en",   int'(serve_en),   0);
    serve_delay();
    check("reserve_en", int'(serve_en), 1);

    // Simultaneous points: re-serve, nothing changes.
    cyc(0, 0, 0, 1, 1);
    check("both_s1",   int'(score_p1),   1);
    check("both_side", int'(serve_side), 1);
    check("both_en",   int'(serve_en),   0);
    serve_delay();

    // Build 3-2, then reset mid-PLAY.
    for (int i = 0; i < 2; i++) begin cyc(0, 0, 0, 1, 0); serve_delay(); end
    for (int i = 0; i < 2; i++) begin cyc(0, 0, 0, 0, 1); serve_delay(); end
    check("mid_s1", int'(score_p1), 3);
    check("mid_s2", int'(score_p2), 2);
    cyc(1, 0, 0, 0, 0);
    check("midrst_s1",   int'(score_p1),   0);
    check("midrst_s2",   int'(score_p2),   0);
    check("midrst_side", int'(serve_side), 0);
    check("midrst_en",   int'(serve_en),   0);

    // Player 2 wins 7-0.
    cyc(0, 1, 0, 0, 0);
    serve_delay();
    for (int i = 0; i < WIN - 1; i++) begin cyc(0, 0, 0, 0, 1); serve_delay(); end
    cyc(0, 0, 0, 0, 1);
    check("win2_s2",   int'(score_p2),  7);
    check("win2_over", int'(game_over), 1);
    check("win2_who",  int'(winner),    2);
    check("win2_en",   int'(serve_en),  0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    check("over_pts_s2", int'(score_p2), 7);
    check("over_pts_s1", int'(score_p1), 0);
    cyc(0, 0, 1, 0, 0); check("blink_1", int'(blink), 1);
    cyc(0, 0, 1, 0, 0); check("blink_2", int'(blink), 0);
    cyc(0, 0, 1, 0, 0); check("blink_3", int'(blink), 1);
    cyc(0, 0, 1, 0, 0); check("blink_4", int'(blink), 0);
    cyc(0, 0, 1, 0, 0); check("blink_5", int'(blink), 1);

    // Restart from GAME_OVER (with a coincident tick): clean slate.
    cyc(0, 1, 1, 0, 0);
    check("restart_s2",    int'(score_p2),  0);
    check("restart_who",   int'(winner),    0);
    check("restart_over",  int'(game_over), 0);
    check("restart_blink", int'(blink),     0);
    check("restart_en",    int'(serve_en),  0);

    // Player 1 wins; serve side survives the next restart.
    serve_delay();
    for (int i = 0; i < WIN - 1; i++) begin cyc(0, 0, 0, 1, 0); serve_delay(); end
    cyc(0, 0, 0, 1, 0);
    check("win1_s1",  int'(score_p1), 7);
    check("win1_who", int'(winner),   1);
    cyc(0, 1, 0, 0, 0);
    check("keep_side", int'(serve_side), 1);
    check("keep_s1",   int'(score_p1),   0);
    serve_delay();
    check("new_match_en", int'(serve_en), 1);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
